// File: rtl/dmem_split_master_pkg.sv
// Shared definitions for the data-memory split master.
//   mem_size_e    : access size encoding used on req_size_i (3 is illegal)
//   dmem_state_e  : sequencing FSM states
//   size_to_mask  : contiguous byte-lane mask for an access of the given size
//   size_to_bytes : byte count for an access of the given size (0 when illegal)
//   needs_split   : true when an access at this byte offset crosses a word boundary
package dmem_split_master_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StBeat0 = 3'd1,
    StBeat1 = 3'd2,
    StCapt  = 3'd3,
    StResp  = 3'd4
  } dmem_state_e;

  function automatic logic [3:0] size_to_mask(input logic [1:0] size);
    logic [3:0] mask;
    case (size)
      MEM_B:   mask = 4'b0001;
      MEM_H:   mask = 4'b0011;
      MEM_W:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    logic [2:0] bytes;
    case (size)
      MEM_B:   bytes = 3'd1;
      MEM_H:   bytes = 3'd2;
      MEM_W:   bytes = 3'd4;
      default: bytes = 3'd0;
    endcase
    return bytes;
  endfunction

  function automatic logic needs_split(input logic [1:0] off, input logic [1:0] size);
    return ({2'b00, off} + {1'b0, size_to_bytes(size)}) > 4'd4;
  endfunction

endpackage

// File: rtl/dmem_split_master_lsu_lane_align.sv
// Combinational lane steering for the data-memory split master.
// Store side: shifts the byte mask and store data up by the byte offset into a 64-bit window;
// the low word feeds the first beat and the high word the second (crossing) beat.
// Load side: shifts the {hi, lo} word pair down by the byte offset, truncates to the access
// size and sign- or zero-extends.
// Ports:
//   off_i         byte offset within the word (addr[1:0])
//   size_i        access size (byte / half / word)
//   unsigned_i    1 = zero-extend loads
//   st_data_i     LSB-justified store data
//   ld_lo_i       read data of the first beat
//   ld_hi_i       read data of the second beat (ignored when not split)
//   ben0_o/ben1_o byte enables for beat 0 / beat 1
//   wdata0_o/wdata1_o lane-shifted store data for beat 0 / beat 1
//   split_o       access touches a second word
//   ld_data_o     extended load result
module dmem_split_master_lsu_lane_align
  import dmem_split_master_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_lo_i,
  input  logic [31:0] ld_hi_i,
  output logic [3:0]  ben0_o,
  output logic [3:0]  ben1_o,
  output logic [31:0] wdata0_o,
  output logic [31:0] wdata1_o,
  output logic        split_o,
  output logic [31:0] ld_data_o
);

  logic [4:0]  shamt;
  logic [7:0]  mask8;
  logic [63:0] st64;
  logic [63:0] ld_cat;
  logic [31:0] ld_sh;

  assign shamt = {off_i, 3'b000};

  assign mask8   = {4'b0000, size_to_mask(size_i)} << off_i;
  assign ben0_o  = mask8[3:0];
  assign ben1_o  = mask8[7:4];
  assign split_o = |mask8[7:4];

  // Upper word of the shifted window equals st_data >> 8*(4-off), and is zero when off = 0.
  assign st64     = {32'h0000_0000, st_data_i} << shamt;
  assign wdata0_o = st64[31:0];
  assign wdata1_o = st64[63:32];

  assign ld_cat = {ld_hi_i, ld_lo_i};
  assign ld_sh  = ld_cat[shamt +: 32];

  always_comb begin
    ld_data_o = ld_sh;
    case (size_i)
      MEM_B:   ld_data_o = {{24{~unsigned_i & ld_sh[7]}}, ld_sh[7:0]};
      MEM_H:   ld_data_o = {{16{~unsigned_i & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_data_o = ld_sh;
    endcase
  end

endmodule

// File: rtl/dmem_split_master.sv
// Core-side initiator for the data-memory interface.
// Accepts one load/store per handshake, issues one aligned word beat (or two when the access
// crosses a word boundary), captures the read data one cycle after each beat and returns a
// single one-cycle response with extended load data.
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   req_valid_i / req_ready_o  request handshake; ready only while idle
//   req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i  request payload
//   resp_valid_o, resp_rdata_o, resp_err_o  one-cycle response
//   dmem_req_o, dmem_addr_o, dmem_wdata_o, dmem_wen_o, dmem_ben_o  beat outputs (0 when idle)
//   dmem_rdata_i               read data for the beat driven in the previous cycle
module dmem_split_master
  import dmem_split_master_pkg::*;
#(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        dmem_req_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic        dmem_wen_o,
  output logic [3:0]  dmem_ben_o,
  input  logic [31:0] dmem_rdata_i
);

  dmem_state_e state_q, state_d;

  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] lo_q;
  logic [31:0] hi_q;

  logic        accept;
  logic        req_err;
  logic        cap_lo;
  logic        cap_hi;

  logic [3:0]  ben0, ben1;
  logic [31:0] wdata0, wdata1;
  logic        split;
  logic [31:0] ld_data;
  logic [31:0] beat0_addr;

  dmem_split_master_lsu_lane_align u_lane_align (
    .off_i      (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .st_data_i  (wdata_q),
    .ld_lo_i    (lo_q),
    .ld_hi_i    (hi_q),
    .ben0_o     (ben0),
    .ben1_o     (ben1),
    .wdata0_o   (wdata0),
    .wdata1_o   (wdata1),
    .split_o    (split),
    .ld_data_o  (ld_data)
  );

  assign beat0_addr = {addr_q[31:2], 2'b00};

  // Errors are decided on the live request so they can skip the memory entirely.
  assign req_err = (req_size_i == 2'd3) ||
                   (!MISALIGN_EN && needs_split(req_addr_i[1:0], req_size_i));

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    cap_lo       = 1'b0;
    cap_hi       = 1'b0;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_rdata_o = 32'h0000_0000;
    resp_err_o   = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_addr_o  = 32'h0000_0000;
    dmem_wdata_o = 32'h0000_0000;
    dmem_wen_o   = 1'b0;
    dmem_ben_o   = 4'b0000;

    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = req_err ? StResp : StBeat0;
        end
      end
      StBeat0: begin
        dmem_req_o   = 1'b1;
        dmem_addr_o  = beat0_addr;
        dmem_ben_o   = ben0;
        dmem_wen_o   = we_q;
        dmem_wdata_o = we_q ? wdata0 : 32'h0000_0000;
        state_d      = split ? StBeat1 : StCapt;
      end
      StBeat1: begin
        dmem_req_o   = 1'b1;
        dmem_addr_o  = beat0_addr + 32'd4;  // wraps mod 2^32
        dmem_ben_o   = ben1;
        dmem_wen_o   = we_q;
        dmem_wdata_o = we_q ? wdata1 : 32'h0000_0000;
        cap_lo       = 1'b1;  // rdata here belongs to beat 0
        state_d      = StCapt;
      end
      StCapt: begin
        cap_lo  = ~split;
        cap_hi  = split;
        state_d = StResp;
      end
      StResp: begin
        resp_valid_o = 1'b1;
        resp_err_o   = err_q;
        resp_rdata_o = (err_q || we_q) ? 32'h0000_0000 : ld_data;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we_i;
      size_q  <= req_size_i;
      uns_q   <= req_unsigned_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
      err_q   <= req_err;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lo_q <= 32'h0000_0000;
      hi_q <= 32'h0000_0000;
    end else begin
      if (cap_lo) lo_q <= dmem_rdata_i;
      if (cap_hi) hi_q <= dmem_rdata_i;
    end
  end

endmodule

// File: tb/tb_dmem_split_master.sv
module tb_dmem_split_master;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  ben;
    logic [31:0] wdata;
    logic        wen;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_wen;
  logic [3:0]  dmem_ben;
  logic [31:0] dmem_rdata = 32'h0;

  // Second instance with crossing accesses disabled.
  logic        n_valid = 1'b0;
  logic        n_ready;
  logic        n_resp_valid;
  logic [31:0] n_resp_rdata;
  logic        n_resp_err;
  logic        n_dmem_req;
  logic [31:0] n_dmem_addr;
  logic [31:0] n_dmem_wdata;
  logic        n_dmem_wen;
  logic [3:0]  n_dmem_ben;
  logic [31:0] n_dmem_rdata = 32'h0;
  int          n_beats = 0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  beat_t beat_q[$];
  resp_t resp_q[$];

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_split_master #(.MISALIGN_EN(1'b1)) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err),
    .dmem_req_o     (dmem_req),
    .dmem_addr_o    (dmem_addr),
    .dmem_wdata_o   (dmem_wdata),
    .dmem_wen_o     (dmem_wen),
    .dmem_ben_o     (dmem_ben),
    .dmem_rdata_i   (dmem_rdata)
  );

  dmem_split_master #(.MISALIGN_EN(1'b0)) u_dut_nm (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (n_valid),
    .req_ready_o    (n_ready),
    .req_we_i       (1'b0),
    .req_size_i     (2'd2),
    .req_unsigned_i (1'b0),
    .req_addr_i     (32'h0000_0101),
    .req_wdata_i    (32'h0),
    .resp_valid_o   (n_resp_valid),
    .resp_rdata_o   (n_resp_rdata),
    .resp_err_o     (n_resp_err),
    .dmem_req_o     (n_dmem_req),
    .dmem_addr_o    (n_dmem_addr),
    .dmem_wdata_o   (n_dmem_wdata),
    .dmem_wen_o     (n_dmem_wen),
    .dmem_ben_o     (n_dmem_ben),
    .dmem_rdata_i   (n_dmem_rdata)
  );

  // Word memory indexed by addr[9:2]; registered read, byte-enabled write, reloaded on reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h40] <= 32'hAABB_CCDD;  // 0x100
      mem[8'h41] <= 32'h1122_3344;  // 0x104
      mem[8'h80] <= 32'h00F0_0000;  // 0x200
      mem[8'hFF] <= 32'h8000_0000;  // 0x3FC, aliases 0xFFFF_FFFC
      mem[8'h00] <= 32'h0000_00FF;  // 0x000
    end else if (dmem_req) begin
      if (dmem_wen) begin
        for (int b = 0; b < 4; b++)
          if (dmem_ben[b]) mem[dmem_addr[9:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
      end else begin
        dmem_rdata <= mem[dmem_addr[9:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] a, input logic [3:0] b, input logic [31:0] w,
                               input logic we);
    beat_t t;
    t.addr = a; t.ben = b; t.wdata = w; t.wen = we;
    return t;
  endfunction

  // Monitor: compare every beat and response against the scoreboard queues.
  always @(negedge clk) begin
    if (dmem_req) begin
      if (beat_q.size() == 0) begin
        chk("unexpected_beat", {32'h0, dmem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        beat_t e;
        e = beat_q.pop_front();
        chk("beat_addr", {32'h0, dmem_addr}, {32'h0, e.addr});
        chk("beat_ben", {60'h0, dmem_ben}, {60'h0, e.ben});
        chk("beat_wen", {63'h0, dmem_wen}, {63'h0, e.wen});
        if (e.wen) chk("beat_wdata", {32'h0, dmem_wdata}, {32'h0, e.wdata});
      end
    end else begin
      chk("dmem_idle_zero", {27'h0, dmem_addr, dmem_ben, dmem_wen},
          {27'h0, 32'h0, 4'h0, 1'b0});
    end
    if (resp_valid) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_resp", {32'h0, resp_rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        chk("resp_rdata", {32'h0, resp_rdata}, {32'h0, r.rdata});
        chk("resp_err", {63'h0, resp_err}, {63'h0, r.err});
        chk("resp_cycle", 64'(cyc), 64'(r.cyc));
      end
    end
    if (n_dmem_req) n_beats++;
  end

  // lat = 0 means no response is expected.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int nb,
                       input beat_t b0, input beat_t b1, input logic [31:0] rdata,
                       input logic err, input int lat);
    resp_t r;
    @(negedge clk);
    chk("req_ready_idle", {63'h0, req_ready}, 64'h1);
    if (nb > 0) beat_q.push_back(b0);
    if (nb > 1) beat_q.push_back(b1);
    if (lat > 0) begin
      r.rdata = rdata; r.err = err; r.cyc = cyc + lat;
      resp_q.push_back(r);
    end
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (resp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (resp_q.size() != 0) begin
      chk("resp_timeout", 64'(resp_q.size()), 64'h0);
      resp_q.delete();
    end
    chk("beats_left", 64'(beat_q.size()), 64'h0);
    beat_q.delete();
  endtask

  beat_t nb0;

  initial begin
    nb0 = mk(32'h0, 4'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'h0, req_ready}, 64'h1);
    chk("rst_outputs", {29'h0, resp_valid, dmem_req, dmem_wen, resp_err},
        {29'h0, 4'b0000});
    chk("rst_data", {resp_rdata, dmem_wdata}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // LH @0x103 crossing: lanes 3 of 0x100 and 0 of 0x104.
    issue(1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 2, mk(32'h100, 4'b1000, 0, 1'b0),
          mk(32'h104, 4'b0001, 0, 1'b0), 32'h0000_44AA, 1'b0, 4);
    wait_done();
    // SW 0xDEADBEEF @0x100.
    issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 1,
          mk(32'h100, 4'b1111, 32'hDEAD_BEEF, 1'b1), nb0, 32'h0, 1'b0, 3);
    wait_done();
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1, mk(32'h100, 4'b1111, 0, 1'b0), nb0,
          32'hDEAD_BEEF, 1'b0, 3);
    wait_done();
    // LBU / LB @0x202 of 0x00F00000.
    issue(1'b0, 2'd0, 1'b1, 32'h202, 32'h0, 1, mk(32'h200, 4'b0100, 0, 1'b0), nb0,
          32'h0000_00F0, 1'b0, 3);
    wait_done();
    issue(1'b0, 2'd0, 1'b0, 32'h202, 32'h0, 1, mk(32'h200, 4'b0100, 0, 1'b0), nb0,
          32'hFFFF_FFF0, 1'b0, 3);
    wait_done();
    // SW 0x11223344 @0x0FE crossing.
    issue(1'b1, 2'd2, 1'b0, 32'h0FE, 32'h1122_3344, 2,
          mk(32'h0FC, 4'b1100, 32'h3344_0000, 1'b1),
          mk(32'h100, 4'b0011, 32'h0000_1122, 1'b1), 32'h0, 1'b0, 4);
    wait_done();
    // Read it back: 0x0FC = 0x33440000, 0x100 = 0xDEAD1122.
    issue(1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0, 2, mk(32'h0FC, 4'b1100, 0, 1'b0),
          mk(32'h100, 4'b0011, 0, 1'b0), 32'h1122_3344, 1'b0, 4);
    wait_done();
    issue(1'b0, 2'd1, 1'b1, 32'h101, 32'h0, 1, mk(32'h100, 4'b0110, 0, 1'b0), nb0,
          32'h0000_AD11, 1'b0, 3);
    wait_done();
    issue(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 1, mk(32'h100, 4'b0110, 0, 1'b0), nb0,
          32'hFFFF_AD11, 1'b0, 3);
    wait_done();
    // Illegal size: no beat, error one cycle after accept.
    issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0, nb0, nb0, 32'h0, 1'b1, 1);
    wait_done();
    // Address wrap: second beat at 0x00000000.
    issue(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0, 2, mk(32'hFFFF_FFFC, 4'b1100, 0, 1'b0),
          mk(32'h0000_0000, 4'b0011, 0, 1'b0), 32'h00FF_8000, 1'b0, 4);
    wait_done();
    // SB @0x003.
    issue(1'b1, 2'd0, 1'b0, 32'h003, 32'hABCD_EF5A, 1,
          mk(32'h000, 4'b1000, 32'h5A00_0000, 1'b1), nb0, 32'h0, 1'b0, 3);
    wait_done();
    issue(1'b0, 2'd2, 1'b0, 32'h000, 32'h0, 1, mk(32'h000, 4'b1111, 0, 1'b0), nb0,
          32'h5A00_00FF, 1'b0, 3);
    wait_done();

    // MISALIGN_EN = 0: LW @0x101 errors without touching memory.
    @(negedge clk);
    chk("nm_ready", {63'h0, n_ready}, 64'h1);
    n_valid = 1'b1;
    @(posedge clk);
    #1 n_valid = 1'b0;
    @(negedge clk);
    chk("nm_resp_valid", {63'h0, n_resp_valid}, 64'h1);
    chk("nm_resp_err", {63'h0, n_resp_err}, 64'h1);
    chk("nm_resp_rdata", {32'h0, n_resp_rdata}, 64'h0);
    repeat (3) @(negedge clk);
    chk("nm_no_beats", 64'(n_beats), 64'h0);
    chk("nm_idle_zero", {n_dmem_addr, n_dmem_wdata}, {32'h0, 4'h0, n_dmem_ben, 23'h0, n_dmem_wen});

    // Reset during BEAT1 of a crossing load: no response, then normal operation.
    issue(1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 1, mk(32'h100, 4'b1000, 0, 1'b0), nb0,
          32'h0, 1'b0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {63'h0, req_ready}, 64'h1);
    chk("midrst_outputs", {28'h0, resp_valid, dmem_req, dmem_wen, resp_err, dmem_ben},
        {28'h0, 8'h00});
    chk("midrst_data", {dmem_addr, dmem_wdata}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    chk("midrst_beats_left", 64'(beat_q.size()), 64'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 1, mk(32'h104, 4'b1111, 0, 1'b0), nb0,
          32'h1122_3344, 1'b0, 3);
    wait_done();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got t=%0t required finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
